spi_param_cmd_decoder: RTL and testbench
========================================

Name: spi_param_cmd_decoder

Overview:
- Command decoder at the SPI-side front of discharge_control. Consumes 16-bit words from the SPI slave PHY and parses fixed-length command frames.
- Produces the machine start/stop ack pulses and the change_*_ack pulses with their held *_data_async words. These feed parameter_generator and discharge_control.
- Validates sync byte, opcode and value range. Counts rejected frames.

Parameters:
FRAME_TIMEOUT, 16'd5000, max cycles between words of one frame (50us @100MHz) before the frame is abandoned
RESET_TON, 16'd10, Ton_data_async reset value (us)
RESET_TOFF, 16'd50, Toff_data_async reset value (us)
RESET_IP, 16'd20, Ip_data_async reset value (A)
RESET_WAVEFORM, 16'h0001, waveform_data_async reset value (buck rectangle)
MAX_IP, 16'd78, largest accepted Ip value

Ports:
clk  input  1  100MHz system clock
rst_n  input  1  synchronous active-low reset
rx_word  input  16  word from SPI PHY
rx_valid  input  1  one-cycle strobe, rx_word valid
machine_start_ack_spi  output  1  one-cycle pulse
machine_stop_ack_spi  output  1  one-cycle pulse
change_Ton_ack  output  1  one-cycle pulse
Ton_data_async  output  16  held Ton value
change_Toff_ack  output  1  one-cycle pulse
Toff_data_async  output  16  held Toff value
change_Ip_ack  output  1  one-cycle pulse
Ip_data_async  output  16  held Ip value
change_waveform_ack  output  1  one-cycle pulse
waveform_data_async  output  16  held waveform value
frame_err  output  1  one-cycle pulse per rejected frame or dropped word
err_count  output  8  saturating count of frame_err pulses

Behaviour:
- Reset (rst_n low at a clk edge):
  - All ack pulses, frame_err and err_count are 0.
  - Data outputs take RESET_* values.
  - FSM goes to IDLE. Reset mid-frame discards the partial frame.
- Frame format:
  - Word0 is the header: [15:8] = 8'hA5, [7:0] = opcode.
  - Word1 is the data word.
- Opcodes:
  - 0x01 start (data ignored).
  - 0x02 stop (data ignored).
  - 0x10 Ton.
  - 0x11 Toff.
  - 0x12 Ip.
  - 0x13 waveform.
- FSM states: IDLE, GET_DATA, [GET_CSUM], COMMIT, ACK.
  - IDLE: on rx_valid, go to GET_DATA if the header sync byte and opcode are valid. Otherwise pulse frame_err and stay in IDLE.
  - GET_DATA: on rx_valid, latch the word, then go to COMMIT (or GET_CSUM if the option is enabled).
  - COMMIT: run the range check. If it passes, update the target data register. If it fails, pulse frame_err and return to IDLE; the data register is unchanged.
  - ACK: assert the matching ack for exactly one cycle, then return to IDLE.
- Latency: final word accepted at cycle N; data register updated at N+1; ack high at N+2. Data is therefore stable at least one cycle before the ack. It holds until the next accepted frame of the same type.
- Range rules:
  - Ton: 1..65535; 0 is rejected.
  - Toff: 1..65535; 0 is rejected.
  - Ip: 1..MAX_IP.
  - Waveform: one of 16'h8000, 16'h0001, 16'h0002.
  - Start/stop: always pass.
- Timeout: a counter runs while in GET_DATA or GET_CSUM and clears on each accepted word. If it reaches FRAME_TIMEOUT, pulse frame_err and return to IDLE.
- rx_valid during COMMIT or ACK: the word is dropped and frame_err pulses. This includes the case where it coincides with the range-fail pulse, which still gives a single frame_err pulse. The FSM sequence is unaffected.
- err_count increments on each frame_err and saturates at 255; it never wraps.
- At most one ack is high in any cycle.

Optional Feature:
- Macro: SPI_CMD_CHECKSUM_EN.
- Defined:
  - Frames are 3 words; word2 = word0 XOR word1.
  - GET_CSUM compares the checksum. On mismatch, frame_err pulses and the FSM returns to IDLE with no register update.
  - Latency is counted from word2.
- Undefined:
  - The GET_CSUM state and its comparator are absent; frames are 2 words.

Decomposition:
- Shared package spi_cmd_pkg holds:
  - Opcode localparams (OP_START, OP_STOP, OP_TON, OP_TOFF, OP_IP, OP_WAVEFORM).
  - SYNC_BYTE = 8'hA5.
  - The waveform code constants (WF_RES = 16'h8000, WF_RECT = 16'h0001, WF_TRI = 16'h0002). discharge_control shares these.
- One natural sub-module: spi_cmd_range_check, a combinational checker (opcode and data in, pass out). It is shared with any future readback path.

Test Plan:
- Reset: after release, Ton/Toff/Ip/waveform read 10/50/20/0001; all acks and err_count are 0.
- Send A510, 0064 (plus checksum 0xA574 when SPI_CMD_CHECKSUM_EN is defined) -> Ton_data_async = 100 at N+1; change_Ton_ack high for exactly 1 cycle at N+2.
- Send A512, 0064 (Ip = 100 > 78) -> no ack; Ip stays 20; frame_err pulses; err_count = 1.
- Send A501, xxxx then A502, xxxx -> machine_start_ack_spi pulses once, then machine_stop_ack_spi pulses once; data outputs unchanged.
- Send header A513, then no word for 5000 cycles, then 0002 -> frame_err from the timeout; 0002 is treated as a bad header, giving a second frame_err; waveform stays 0001.
- Send 300 bad headers (1234) -> err_count saturates at 255; then a valid Toff frame still decodes correctly.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, sync byte, waveform codes and FSM states for the SPI command path.
// SPI_CMD_CHECKSUM_EN adds the GET_CSUM state for 3-word frames.
package spi_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;

  localparam logic [7:0] OP_START    = 8'h01;
  localparam logic [7:0] OP_STOP     = 8'h02;
  localparam logic [7:0] OP_TON      = 8'h10;
  localparam logic [7:0] OP_TOFF     = 8'h11;
  localparam logic [7:0] OP_IP       = 8'h12;
  localparam logic [7:0] OP_WAVEFORM = 8'h13;

  localparam logic [15:0] WF_RES  = 16'h8000;
  localparam logic [15:0] WF_RECT = 16'h0001;
  localparam logic [15:0] WF_TRI  = 16'h0002;

  // Ack vector bit order: start, stop, Ton, Toff, Ip, waveform.
  localparam int ACK_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_DATA,
`ifdef SPI_CMD_CHECKSUM_EN
    ST_GET_CSUM,
`endif
    ST_COMMIT,
    ST_ACK
  } state_e;

  function automatic logic op_valid(
    input logic [7:0] op
  );
    return op inside {OP_START, OP_STOP, OP_TON,
                      OP_TOFF, OP_IP, OP_WAVEFORM};
  endfunction

  function automatic logic [ACK_W-1:0] op_ack(
    input logic [7:0] op
  );
    logic [ACK_W-1:0] a;
    a = '0;
    unique case (1'b1)
      (op == OP_START):    a[0] = 1'b1;
      (op == OP_STOP):     a[1] = 1'b1;
      (op == OP_TON):      a[2] = 1'b1;
      (op == OP_TOFF):     a[3] = 1'b1;
      (op == OP_IP):       a[4] = 1'b1;
      (op == OP_WAVEFORM): a[5] = 1'b1;
      default:             a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/spi_cmd_range_check.sv
// Combinational value-range check for one decoded command.
// Shared by the write path and any later readback path.
module spi_cmd_range_check #(
  parameter logic [15:0] MAX_IP = 16'd78
) (
  input  logic [7:0]  opcode,
  input  logic [15:0] data,
  output logic        pass
);
  import spi_cmd_pkg::*;

  always_comb begin
    pass = 1'b0;
    unique case (1'b1)
      (opcode == OP_START),
      (opcode == OP_STOP):
        pass = 1'b1;
      (opcode == OP_TON),
      (opcode == OP_TOFF):
        pass = (data != 16'd0);
      (opcode == OP_IP):
        pass = (data != 16'd0) && (data <= MAX_IP);
      (opcode == OP_WAVEFORM):
        pass = (data == WF_RES) ||
               (data == WF_RECT) ||
               (data == WF_TRI);
      default:
        pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/spi_param_cmd_decoder.sv
// SPI command frame decoder: header/data[/checksum] -> range check -> ack pulses.
// Define SPI_CMD_CHECKSUM_EN for 3-word frames with an XOR checksum word.
module spi_param_cmd_decoder #(
  parameter logic [15:0] FRAME_TIMEOUT  = 16'd5000,
  parameter logic [15:0] RESET_TON      = 16'd10,
  parameter logic [15:0] RESET_TOFF     = 16'd50,
  parameter logic [15:0] RESET_IP       = 16'd20,
  parameter logic [15:0] RESET_WAVEFORM = 16'h0001,
  parameter logic [15:0] MAX_IP         = 16'd78
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] rx_word,
  input  logic        rx_valid,
  output logic        machine_start_ack_spi,
  output logic        machine_stop_ack_spi,
  output logic        change_Ton_ack,
  output logic [15:0] Ton_data_async,
  output logic        change_Toff_ack,
  output logic [15:0] Toff_data_async,
  output logic        change_Ip_ack,
  output logic [15:0] Ip_data_async,
  output logic        change_waveform_ack,
  output logic [15:0] waveform_data_async,
  output logic        frame_err,
  output logic [7:0]  err_count
);
  import spi_cmd_pkg::*;

  state_e             state_q, state_d;
  logic [7:0]         op_q, op_d;
  logic [15:0]        data_q, data_d;
  logic [15:0]        tmo_q, tmo_d;
  logic [15:0]        ton_q, ton_d;
  logic [15:0]        toff_q, toff_d;
  logic [15:0]        ip_q, ip_d;
  logic [15:0]        wf_q, wf_d;
  logic [ACK_W-1:0]   ack_q, ack_d;
  logic               frame_err_q, frame_err_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic               range_pass;
  logic               hdr_ok;
  logic               tmo_hit;
`ifdef SPI_CMD_CHECKSUM_EN
  logic               csum_ok;
`endif

  spi_cmd_range_check #(
    .MAX_IP (MAX_IP)
  ) u_range (
    .opcode (op_q),
    .data   (data_q),
    .pass   (range_pass)
  );

  assign hdr_ok  = (rx_word[15:8] == SYNC_BYTE) &&
                   op_valid(rx_word[7:0]);
  assign tmo_hit = (tmo_q == FRAME_TIMEOUT - 16'd1);
`ifdef SPI_CMD_CHECKSUM_EN
  assign csum_ok = (rx_word == ({SYNC_BYTE, op_q} ^ data_q));
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    tmo_d       = tmo_q;
    ton_d       = ton_q;
    toff_d      = toff_q;
    ip_d        = ip_q;
    wf_d        = wf_q;
    ack_d       = '0;
    frame_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (rx_valid) begin
          if (hdr_ok) begin
            op_d    = rx_word[7:0];
            state_d = ST_GET_DATA;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      ST_GET_DATA: begin
        if (rx_valid) begin
          data_d = rx_word;
          tmo_d  = '0;
`ifdef SPI_CMD_CHECKSUM_EN
          state_d = ST_GET_CSUM;
`else
          state_d = ST_COMMIT;
`endif
        end else if (tmo_hit) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
`ifdef SPI_CMD_CHECKSUM_EN
      ST_GET_CSUM: begin
        if (rx_valid) begin
          tmo_d = '0;
          if (csum_ok) begin
            state_d = ST_COMMIT;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end else if (tmo_hit) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
`endif
      ST_COMMIT: begin
        // A word arriving here is dropped; merges with a range-fail pulse.
        if (rx_valid) frame_err_d = 1'b1;
        if (range_pass) begin
          unique case (1'b1)
            (op_q == OP_TON):      ton_d  = data_q;
            (op_q == OP_TOFF):     toff_d = data_q;
            (op_q == OP_IP):       ip_d   = data_q;
            (op_q == OP_WAVEFORM): wf_d   = data_q;
            default: ;
          endcase
          state_d = ST_ACK;
        end else begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (rx_valid) frame_err_d = 1'b1;
        ack_d   = op_ack(op_q);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    err_cnt_d = err_cnt_q;
    if (frame_err_d && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      data_q      <= '0;
      tmo_q       <= '0;
      ton_q       <= RESET_TON;
      toff_q      <= RESET_TOFF;
      ip_q        <= RESET_IP;
      wf_q        <= RESET_WAVEFORM;
      ack_q       <= '0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      tmo_q       <= tmo_d;
      ton_q       <= ton_d;
      toff_q      <= toff_d;
      ip_q        <= ip_d;
      wf_q        <= wf_d;
      ack_q       <= ack_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign machine_start_ack_spi = ack_q[0];
  assign machine_stop_ack_spi  = ack_q[1];
  assign change_Ton_ack        = ack_q[2];
  assign change_Toff_ack       = ack_q[3];
  assign change_Ip_ack         = ack_q[4];
  assign change_waveform_ack   = ack_q[5];
  assign Ton_data_async        = ton_q;
  assign Toff_data_async       = toff_q;
  assign Ip_data_async         = ip_q;
  assign waveform_data_async   = wf_q;
  assign frame_err             = frame_err_q;
  assign err_count             = err_cnt_q;

endmodule

// File: tb/tb_spi_param_cmd_decoder.sv
// Scoreboard bench for spi_param_cmd_decoder: expected acks/errors queued at
// stimulus time and popped by a negedge monitor.
module tb_spi_param_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rx_word;
  logic        rx_valid;
  logic        start_ack, stop_ack;
  logic        ton_ack, toff_ack, ip_ack, wf_ack;
  logic [15:0] ton, toff, ip, wf;
  logic        frame_err;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  spi_param_cmd_decoder dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .rx_word               (rx_word),
    .rx_valid              (rx_valid),
    .machine_start_ack_spi (start_ack),
    .machine_stop_ack_spi  (stop_ack),
    .change_Ton_ack        (ton_ack),
    .Ton_data_async        (ton),
    .change_Toff_ack       (toff_ack),
    .Toff_data_async       (toff),
    .change_Ip_ack         (ip_ack),
    .Ip_data_async         (ip),
    .change_waveform_ack   (wf_ack),
    .waveform_data_async   (wf),
    .frame_err             (frame_err),
    .err_count             (err_count)
  );

  typedef struct {
    int          kind;
    logic [15:0] data;
  } exp_t;

  localparam int K_ERR = 6;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  int   exp_err = 0;
  logic [15:0] m_ton  = 16'd10;
  logic [15:0] m_toff = 16'd50;
  logic [15:0] m_ip   = 16'd20;
  logic [15:0] m_wf   = 16'h0001;

  // Monitor: pops one expectation per ack pulse and per frame_err pulse.
  logic [15:0] prev_val [6];
  always @(negedge clk) begin : mon
    logic [5:0] acks;
    int         kind;
    exp_t       e;
    acks = {wf_ack, ip_ack, toff_ack, ton_ack, stop_ack, start_ack};
    if (rst_n === 1'b1) begin
      if ($countones(acks) > 1) begin
        vectors++;
        errors++;
        $display("FAIL one_ack got %b required at most one bit", acks);
      end
      if (acks != 6'd0) begin
        kind = 0;
        for (int i = 0; i < 6; i++) if (acks[i]) kind = i;
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack got kind %0d required none", kind);
        end else begin
          e = sb.pop_front();
          if (e.kind != kind) begin
            errors++;
            $display("FAIL ack_kind got %0d required %0d", kind, e.kind);
          end else if (kind >= 2 && prev_val[kind] !== e.data) begin
            errors++;
            $display("FAIL ack_data_prev_cycle got %h required %h",
                     prev_val[kind], e.data);
          end
        end
      end
      if (frame_err === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame_err got 1 required none");
        end else begin
          e = sb.pop_front();
          if (e.kind != K_ERR) begin
            errors++;
            $display("FAIL err_kind got frame_err required kind %0d", e.kind);
          end
        end
      end
    end
    prev_val[0] = 16'd0;
    prev_val[1] = 16'd0;
    prev_val[2] = ton;
    prev_val[3] = toff;
    prev_val[4] = ip;
    prev_val[5] = wf;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic word(input logic [15:0] w);
    rx_word  = w;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_err();
    exp_t e;
    e.kind = K_ERR;
    e.data = 16'h0;
    sb.push_back(e);
    if (exp_err < 255) exp_err++;
  endtask

  task automatic push_ack(input logic [7:0] op, input logic [15:0] d);
    exp_t e;
    case (op)
      8'h01:   e.kind = 0;
      8'h02:   e.kind = 1;
      8'h10:   begin e.kind = 2; m_ton  = d; end
      8'h11:   begin e.kind = 3; m_toff = d; end
      8'h12:   begin e.kind = 4; m_ip   = d; end
      default: begin e.kind = 5; m_wf   = d; end
    endcase
    e.data = d;
    sb.push_back(e);
  endtask

  // Header, data (and checksum), then two idle cycles so the next header lands in IDLE.
  task automatic send_frame(input logic [7:0] op, input logic [15:0] d,
                            input bit ok);
    logic [15:0] hdr;
    hdr = {8'hA5, op};
    if (ok) push_ack(op, d);
    else    push_err();
    word(hdr);
    word(d);
`ifdef SPI_CMD_CHECKSUM_EN
    word(hdr ^ d);
`endif
    idle(2);
  endtask

  task automatic check_state(input string tag);
    idle(4);
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got %0d required 0", tag, sb.size());
      sb.delete();
    end
    vectors++;
    if (err_count !== exp_err[7:0]) begin
      errors++;
      $display("FAIL %s_err_count got %0d required %0d", tag, err_count, exp_err);
    end
    vectors++;
    if ({ton, toff, ip, wf} !== {m_ton, m_toff, m_ip, m_wf}) begin
      errors++;
      $display("FAIL %s_data got %h/%h/%h/%h required %h/%h/%h/%h", tag,
               ton, toff, ip, wf, m_ton, m_toff, m_ip, m_wf);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_word  = 16'h0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    vectors++;
    if ({ton, toff, ip, wf} !== {16'd10, 16'd50, 16'd20, 16'h0001}) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h/%h required 000a/0032/0014/0001",
               ton, toff, ip, wf);
    end
    vectors++;
    if ({start_ack, stop_ack, ton_ack, toff_ack, ip_ack, wf_ack, frame_err}
        !== 7'd0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_flags got acks/err %b cnt %0d required 0",
               {start_ack, stop_ack, ton_ack, toff_ack, ip_ack, wf_ack,
                frame_err}, err_count);
    end
  endtask

  task automatic test_ton_latency();
    push_ack(8'h10, 16'h0064);
    word(16'hA510);
`ifdef SPI_CMD_CHECKSUM_EN
    word(16'h0064);
    word(16'hA574);
`else
    word(16'h0064);
`endif
    vectors++;
    if (ton !== 16'd10) begin
      errors++;
      $display("FAIL ton_n got %0d required 10", ton);
    end
    idle(1);
    vectors++;
    if (ton !== 16'd100 || ton_ack !== 1'b0) begin
      errors++;
      $display("FAIL ton_n1 got %0d ack %b required 100 ack 0", ton, ton_ack);
    end
    idle(1);
    vectors++;
    if (ton_ack !== 1'b1) begin
      errors++;
      $display("FAIL ton_ack_n2 got %b required 1", ton_ack);
    end
    idle(1);
    vectors++;
    if (ton_ack !== 1'b0) begin
      errors++;
      $display("FAIL ton_ack_n3 got %b required 0", ton_ack);
    end
    check_state("ton");
  endtask

  task automatic test_ip_range();
    send_frame(8'h12, 16'h0064, 1'b0);
    check_state("ip_over");
  endtask

  task automatic test_start_stop();
    send_frame(8'h01, 16'h1234, 1'b1);
    send_frame(8'h02, 16'h5678, 1'b1);
    check_state("start_stop");
  endtask

  task automatic test_back_to_back();
    send_frame(8'h10, 16'h0001, 1'b1);
    send_frame(8'h11, 16'hFFFF, 1'b1);
    send_frame(8'h12, 16'd78, 1'b1);
    send_frame(8'h12, 16'd79, 1'b0);
    send_frame(8'h11, 16'h0000, 1'b0);
    send_frame(8'h13, 16'h8000, 1'b1);
    send_frame(8'h13, 16'h0003, 1'b0);
    send_frame(8'h13, 16'h0002, 1'b1);
    send_frame(8'h13, 16'h0001, 1'b1);
    check_state("b2b");
  endtask

  task automatic test_drop();
    push_err();
    push_ack(8'h10, 16'h0020);
    word(16'hA510);
    word(16'h0020);
`ifdef SPI_CMD_CHECKSUM_EN
    word(16'hA530);
`endif
    word(16'hDEAD);
    idle(3);
    push_err();
    word(16'hA512);
    word(16'h0000);
`ifdef SPI_CMD_CHECKSUM_EN
    word(16'hA512);
`endif
    word(16'hBEEF);
    check_state("drop");
  endtask

  task automatic test_timeout();
    push_ack(8'h10, 16'h0007);
    word(16'hA510);
    idle(4999);
    word(16'h0007);
`ifdef SPI_CMD_CHECKSUM_EN
    word(16'hA517);
`endif
    check_state("tmo_edge");
    push_err();
    push_err();
    word(16'hA513);
    idle(5000);
    word(16'h0002);
    check_state("tmo");
  endtask

  task automatic test_reset_mid_frame();
    word(16'hA510);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    m_ton   = 16'd10;
    m_toff  = 16'd50;
    m_ip    = 16'd20;
    m_wf    = 16'h0001;
    exp_err = 0;
    push_err();
    word(16'h0064);
    check_state("mid_reset");
  endtask

  task automatic test_saturation();
    repeat (300) begin
      push_err();
      word(16'h1234);
    end
    check_state("sat");
    vectors++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_value got %0d required 255", err_count);
    end
    send_frame(8'h11, 16'h0100, 1'b1);
    push_err();
    word(16'h1234);
    check_state("sat_after");
  endtask

  initial begin
    test_reset();
    test_ton_latency();
    test_ip_range();
    test_start_stop();
    test_back_to_back();
    test_drop();
    test_timeout();
    test_reset_mid_frame();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
